// File: rtl/dbus_pkg.sv
// dbus_pkg: shared byte width and FSM state types for the D-bus/UART bridge.
package dbus_pkg;
    localparam int c_BYTE_W = 8;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_XFER} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_W1, R_W2} rx_state_t;
endpackage

// File: rtl/dbus_sync_fifo.sv
// dbus_sync_fifo: single-clock FIFO with flush; occupancy from natural pointer wrap.
module dbus_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic             w_wr, w_rd;

    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = o_level == DEPTH[AW:0];
    assign o_empty = o_level == '0;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr    = i_push & ~o_full;
    assign w_rd    = i_pop & ~o_empty;

    always_ff @(posedge i_clock) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_wr};
            r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, w_rd};
        end
    end
endmodule

// File: rtl/dbus_uart_bridge.sv
// dbus_uart_bridge: buffers bytes between UART and D-bus transceiver in both directions.
// Define DBUS_TIMEOUT_FLUSH_EN to let i_dbus_reset flush both FIFOs and idle both FSMs.
module dbus_uart_bridge
    import dbus_pkg::*;
#(
    parameter int c_DEPTH = 16,
    localparam int c_AW = $clog2(c_DEPTH)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [c_BYTE_W-1:0] i_uart_rx_data,
    input  logic                i_uart_rx_valid,
    output logic [c_BYTE_W-1:0] o_uart_tx_data,
    output logic                o_uart_tx_start,
    input  logic                i_uart_tx_busy,
    output logic [c_BYTE_W-1:0] o_dbus_data,
    output logic                o_dbus_enable,
    output logic                o_dbus_read,
    input  logic [c_BYTE_W-1:0] i_dbus_data,
    input  logic                i_dbus_busy,
    input  logic                i_dbus_avail,
    input  logic                i_dbus_receiving,
    input  logic                i_dbus_reset,
    output logic                o_tx_overflow,
    output logic [c_AW:0]       o_tx_level,
    output logic [c_AW:0]       o_rx_level
);
    tx_state_t           r_tx_state;
    rx_state_t           r_rx_state;
    logic [c_BYTE_W-1:0] w_tx_head, w_rx_head;
    logic                w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic                w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_flush;

`ifdef DBUS_TIMEOUT_FLUSH_EN
    assign w_flush = i_dbus_reset;
`else
    assign w_flush = 1'b0 & i_dbus_reset;
`endif

    assign w_tx_push = i_uart_rx_valid & ~w_tx_full;
    assign w_tx_pop  = (r_tx_state == T_REQ) & i_dbus_busy & ~i_dbus_receiving & ~w_flush;
    assign w_rx_push = (r_rx_state == R_IDLE) & i_dbus_avail & ~w_rx_full & ~w_flush;
    // Holdoff after a start covers the UART transmitter's busy latency.
    assign w_rx_pop  = ~w_rx_empty & ~i_uart_tx_busy & ~o_uart_tx_start & ~w_flush;

    dbus_sync_fifo #(.DEPTH(c_DEPTH), .WIDTH(c_BYTE_W)) u_tx_fifo (
        .i_clock(i_clock), .i_reset(i_reset), .i_flush(w_flush),
        .i_push(w_tx_push), .i_pop(w_tx_pop), .i_data(i_uart_rx_data), .o_data(w_tx_head),
        .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(o_tx_level)
    );

    dbus_sync_fifo #(.DEPTH(c_DEPTH), .WIDTH(c_BYTE_W)) u_rx_fifo (
        .i_clock(i_clock), .i_reset(i_reset), .i_flush(w_flush),
        .i_push(w_rx_push), .i_pop(w_rx_pop), .i_data(i_dbus_data), .o_data(w_rx_head),
        .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(o_rx_level)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tx_state    <= T_IDLE;
            o_dbus_data   <= '0;
            o_dbus_enable <= 1'b0;
        end else if (w_flush) begin
            r_tx_state    <= T_IDLE;
            o_dbus_enable <= 1'b0;
        end else begin
            case (r_tx_state)
                T_IDLE: if (!w_tx_empty && !i_dbus_busy) begin
                    o_dbus_data   <= w_tx_head;
                    o_dbus_enable <= 1'b1;
                    r_tx_state    <= T_REQ;
                end
                T_REQ: if (i_dbus_busy) begin
                    o_dbus_enable <= 1'b0;
                    r_tx_state    <= i_dbus_receiving ? T_IDLE : T_XFER;
                end
                T_XFER: if (!i_dbus_busy) r_tx_state <= T_IDLE;
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    // Wait states let the transceiver clear avail before it is looked at again.
    always_ff @(posedge i_clock) begin
        if (i_reset || w_flush) begin
            r_rx_state  <= R_IDLE;
            o_dbus_read <= 1'b0;
        end else begin
            o_dbus_read <= w_rx_push;
            case (r_rx_state)
                R_IDLE:  r_rx_state <= w_rx_push ? R_W1 : R_IDLE;
                R_W1:    r_rx_state <= R_W2;
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_uart_tx_data  <= '0;
            o_uart_tx_start <= 1'b0;
            o_tx_overflow   <= 1'b0;
        end else begin
            o_uart_tx_start <= w_rx_pop;
            if (w_rx_pop) o_uart_tx_data <= w_rx_head;
            if (i_uart_rx_valid && w_tx_full) o_tx_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dbus_uart_bridge.sv
// tb_dbus_uart_bridge: directed vectors with hand-computed expectations for dbus_uart_bridge.
module tb_dbus_uart_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] uart_rx_data, uart_tx_data, dbus_data_o, dbus_data_i;
    logic       uart_rx_valid, uart_tx_start, uart_tx_busy;
    logic       dbus_enable, dbus_read, dbus_busy, dbus_avail, dbus_receiving, dbus_reset;
    logic       tx_overflow;
    logic [4:0] tx_level, rx_level;
    int         n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    dbus_uart_bridge #(.c_DEPTH(16)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_uart_rx_data(uart_rx_data), .i_uart_rx_valid(uart_rx_valid),
        .o_uart_tx_data(uart_tx_data), .o_uart_tx_start(uart_tx_start), .i_uart_tx_busy(uart_tx_busy),
        .o_dbus_data(dbus_data_o), .o_dbus_enable(dbus_enable), .o_dbus_read(dbus_read),
        .i_dbus_data(dbus_data_i), .i_dbus_busy(dbus_busy), .i_dbus_avail(dbus_avail),
        .i_dbus_receiving(dbus_receiving), .i_dbus_reset(dbus_reset),
        .o_tx_overflow(tx_overflow), .o_tx_level(tx_level), .o_rx_level(rx_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int reads;
        int k;
        {uart_rx_data, uart_rx_valid, uart_tx_busy, dbus_data_i} = '0;
        {dbus_busy, dbus_avail, dbus_receiving, dbus_reset} = '0;
        do_reset();
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_enable", dbus_enable, 0);
        chk("rst_dbus_data", dbus_data_o, 0);
        chk("rst_read", dbus_read, 0);
        chk("rst_start", uart_tx_start, 0);
        chk("rst_ovf", tx_overflow, 0);

        // UART byte goes out through enable/busy handshake
        uart_rx_data = 8'hA5; uart_rx_valid = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
        chk("t1_level_push", tx_level, 1);
        chk("t1_enable_pre", dbus_enable, 0);
        tick();
        chk("t1_enable_req", dbus_enable, 1);
        chk("t1_data_req", dbus_data_o, 8'hA5);
        tick();
        chk("t1_enable_hold", dbus_enable, 1);
        chk("t1_data_hold", dbus_data_o, 8'hA5);
        chk("t1_level_hold", tx_level, 1);
        dbus_busy = 1'b1;
        tick();
        chk("t1_enable_drop", dbus_enable, 0);
        chk("t1_level_pop", tx_level, 0);
        tick();
        chk("t1_level_xfer", tx_level, 0);
        dbus_busy = 1'b0;
        tick();
        tick();
        chk("t1_no_resend", dbus_enable, 0);

        // Transceiver byte goes out through UART
        dbus_avail = 1'b1; dbus_data_i = 8'h3C;
        tick();
        chk("t2_read", dbus_read, 1);
        chk("t2_rx_level", rx_level, 1);
        tick();
        chk("t2_read_once", dbus_read, 0);
        chk("t2_start", uart_tx_start, 1);
        chk("t2_tx_data", uart_tx_data, 8'h3C);
        chk("t2_rx_level_pop", rx_level, 0);
        tick();
        chk("t2_no_read_w2", dbus_read, 0);
        chk("t2_start_pulse", uart_tx_start, 0);
        dbus_avail = 1'b0;
        tick();
        chk("t2_no_read_idle", dbus_read, 0);

        // TX overflow with transceiver busy
        dbus_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            uart_rx_data = 8'(i); uart_rx_valid = 1'b1;
            tick();
        end
        chk("t3_level_full", tx_level, 16);
        chk("t3_ovf_clear", tx_overflow, 0);
        chk("t3_no_enable", dbus_enable, 0);
        uart_rx_data = 8'hEE;
        tick();
        uart_rx_valid = 1'b0;
        chk("t3_level_drop", tx_level, 16);
        chk("t3_ovf_set", tx_overflow, 1);
        tick();
        chk("t3_ovf_sticky", tx_overflow, 1);
        dbus_busy = 1'b0;
        do_reset();
        chk("t3_ovf_rst", tx_overflow, 0);

        // Link-side receive wins during request
        uart_rx_data = 8'h77; uart_rx_valid = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
        tick();
        chk("t4_enable_req", dbus_enable, 1);
        dbus_busy = 1'b1; dbus_receiving = 1'b1;
        tick();
        chk("t4_enable_drop", dbus_enable, 0);
        chk("t4_no_pop", tx_level, 1);
        tick();
        chk("t4_idle_wait", dbus_enable, 0);
        dbus_busy = 1'b0; dbus_receiving = 1'b0;
        tick();
        chk("t4_retry_enable", dbus_enable, 1);
        chk("t4_retry_data", dbus_data_o, 8'h77);
        dbus_busy = 1'b1;
        tick();
        chk("t4_pop", tx_level, 0);
        chk("t4_enable_off", dbus_enable, 0);
        dbus_busy = 1'b0;
        tick();

        // RX FIFO full stalls reads until UART drains one
        uart_tx_busy = 1'b1; dbus_avail = 1'b1;
        reads = 0;
        k = 0;
        while (rx_level != 16 && k < 200) begin
            dbus_data_i = 8'(8'h10 + reads);
            tick();
            if (dbus_read) reads++;
            k++;
        end
        chk("t5_rx_full", rx_level, 16);
        chk("t5_reads", reads, 16);
        reads = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dbus_read) reads++;
        end
        chk("t5_stall_reads", reads, 0);
        chk("t5_no_start", uart_tx_start, 0);
        uart_tx_busy = 1'b0;
        tick();
        uart_tx_busy = 1'b1;
        chk("t5_start", uart_tx_start, 1);
        chk("t5_first_byte", uart_tx_data, 8'h10);
        chk("t5_level_drain", rx_level, 15);
        chk("t5_read_held", dbus_read, 0);
        tick();
        chk("t5_read_resume", dbus_read, 1);
        chk("t5_level_refill", rx_level, 16);
        dbus_avail = 1'b0;
        tick();
        tick();

`ifdef DBUS_TIMEOUT_FLUSH_EN
        do_reset();
        dbus_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            uart_rx_data = 8'(i); uart_rx_valid = 1'b1;
            tick();
        end
        uart_rx_valid = 1'b0;
        dbus_avail = 1'b1;
        tick();
        dbus_avail = 1'b0;
        tick();
        tick();
        dbus_avail = 1'b1;
        tick();
        dbus_avail = 1'b0;
        chk("t6_tx_pre", tx_level, 3);
        chk("t6_rx_pre", rx_level, 2);
        dbus_reset = 1'b1;
        tick();
        dbus_reset = 1'b0;
        chk("t6_tx_flush", tx_level, 0);
        chk("t6_rx_flush", rx_level, 0);
        chk("t6_enable", dbus_enable, 0);
        dbus_busy = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
